// File: rtl/pi_switch_fifo.sv
// Four-port tree switch (l, r, u0, u1) with a FIFO on every input and one
// registered output per port. Down-bound traffic is steered by the address bit
// that belongs to this tree level. Up-bound traffic leaves on u0 (from l) or
// u1 (from r). The l and r outputs each arbitrate three sources, either
// round-robin or by fixed priority.
module pi_switch_fifo #(
  parameter int N     = 4,
  parameter int A_W   = $clog2(N) + 1,
  parameter int D_W   = 32,
  parameter int posl  = 0,
  parameter int posx  = 0,
  parameter int DEPTH = 4,
  parameter int RR    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [A_W+D_W:0] l_i,
  input  logic             l_i_v,
  output logic             l_i_bp,
  input  logic [A_W+D_W:0] r_i,
  input  logic             r_i_v,
  output logic             r_i_bp,
  input  logic [A_W+D_W:0] u0_i,
  input  logic             u0_i_v,
  output logic             u0_i_bp,
  input  logic [A_W+D_W:0] u1_i,
  input  logic             u1_i_v,
  output logic             u1_i_bp,
  output logic [A_W+D_W:0] l_o,
  output logic             l_o_v,
  input  logic             l_o_bp,
  output logic [A_W+D_W:0] r_o,
  output logic             r_o_v,
  input  logic             r_o_bp,
  output logic [A_W+D_W:0] u0_o,
  output logic             u0_o_v,
  input  logic             u0_o_bp,
  output logic [A_W+D_W:0] u1_o,
  output logic             u1_o_v,
  input  logic             u1_o_bp,
  output logic             done
);

  localparam int FW = A_W + D_W + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  // Port indices, used for both the input side and the output side.
  localparam logic [1:0] P_L  = 2'd0;
  localparam logic [1:0] P_R  = 2'd1;
  localparam logic [1:0] P_U0 = 2'd2;
  localparam logic [1:0] P_U1 = 2'd3;
  // Address bits above this level that identify the subtree this switch owns.
  localparam logic [A_W-1:0] POSX_HI = A_W'(posx >> (posl + 1));

  // Picks the first requester at or after `start`, wrapping over three sources.
  function automatic logic [2:0] arb3(input logic [2:0] req, input logic [1:0] start);
    logic [2:0] gnt;
    logic [1:0] k;
    gnt = '0;
    k   = start;
    for (int n = 0; n < 3; n++) begin
      if (gnt == '0 && req[k]) gnt[k] = 1'b1;
      k = (k == 2'd2) ? 2'd0 : k + 2'd1;
    end
    return gnt;
  endfunction

  // After a grant to source k, the pointer moves to k+1 mod 3; with no grant it holds.
  function automatic logic [1:0] next_ptr(input logic [2:0] gnt, input logic [1:0] ptr);
    if (gnt[0])      return 2'd1;
    else if (gnt[1]) return 2'd2;
    else if (gnt[2]) return 2'd0;
    return ptr;
  endfunction

  logic [FW-1:0]  in_flit [4];
  logic [3:0]     in_vld;
  logic [3:0]     in_bp;
  logic [3:0]     push;
  logic [3:0]     pop;
  logic [3:0]     nonempty;
  logic [FW-1:0]  mem [4][DEPTH];
  logic [PW-1:0]  wr_ptr [4];
  logic [PW-1:0]  rd_ptr [4];
  logic [CW-1:0]  cnt [4];
  logic [FW-1:0]  head [4];
  logic [A_W-1:0] head_addr [4];
  logic [3:0]     head_down;
  logic [1:0]     dest [4];

  logic [FW-1:0]  sel [4];
  logic [FW-1:0]  flit_p1 [4];
  logic [3:0]     vld_p1;
  logic [3:0]     out_bp;
  logic [3:0]     out_rdy;
  logic [3:0]     ld;
  logic [2:0]     req_l;
  logic [2:0]     req_r;
  logic [2:0]     gnt_l;
  logic [2:0]     gnt_r;
  logic [1:0]     ptr_l;
  logic [1:0]     ptr_r;

  assign in_flit[0] = l_i;
  assign in_flit[1] = r_i;
  assign in_flit[2] = u0_i;
  assign in_flit[3] = u1_i;
  assign in_vld     = {u1_i_v, u0_i_v, r_i_v, l_i_v};
  assign out_bp     = {u1_o_bp, u0_o_bp, r_o_bp, l_o_bp};

  assign l_i_bp  = in_bp[0];
  assign r_i_bp  = in_bp[1];
  assign u0_i_bp = in_bp[2];
  assign u1_i_bp = in_bp[3];

  assign l_o  = flit_p1[0];
  assign r_o  = flit_p1[1];
  assign u0_o = flit_p1[2];
  assign u1_o = flit_p1[3];
  assign l_o_v  = vld_p1[0];
  assign r_o_v  = vld_p1[1];
  assign u0_o_v = vld_p1[2];
  assign u1_o_v = vld_p1[3];

  assign push = in_vld & ~in_bp;

  // FIFO status from registered occupancy; a same-cycle pop does not lift backpressure.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_bp[i]    = (cnt[i] == FULL);
      nonempty[i] = (cnt[i] != '0);
      head[i]     = mem[i][rd_ptr[i]];
    end
  end

  // Route each FIFO head to exactly one output; up inputs always go down.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head_addr[i] = head[i][FW-2:D_W];
      head_down[i] = ((head_addr[i] >> (posl + 1)) == POSX_HI);
      if (i >= 2 || head_down[i]) dest[i] = head_addr[i][posl] ? P_R : P_L;
      else                        dest[i] = (i == 0) ? P_U0 : P_U1;
    end
  end

  // Requests, arbitration and the pop that accompanies every output load.
  always_comb begin
    out_rdy = ~vld_p1 | ~out_bp;
    req_l   = {nonempty[3] && dest[3] == P_L, nonempty[2] && dest[2] == P_L,
               nonempty[1] && dest[1] == P_L};
    req_r   = {nonempty[3] && dest[3] == P_R, nonempty[2] && dest[2] == P_R,
               nonempty[0] && dest[0] == P_R};
    gnt_l   = arb3(req_l, (RR != 0) ? ptr_l : 2'd0);
    gnt_r   = arb3(req_r, (RR != 0) ? ptr_r : 2'd0);
    ld      = '0;
    ld[0]   = out_rdy[0] && (req_l != '0);
    ld[1]   = out_rdy[1] && (req_r != '0);
    ld[2]   = out_rdy[2] && nonempty[0] && dest[0] == P_U0;
    ld[3]   = out_rdy[3] && nonempty[1] && dest[1] == P_U1;
    pop     = '0;
    pop[0]  = (ld[1] && gnt_r[0]) || ld[2];
    pop[1]  = (ld[0] && gnt_l[0]) || ld[3];
    pop[2]  = (ld[0] && gnt_l[1]) || (ld[1] && gnt_r[1]);
    pop[3]  = (ld[0] && gnt_l[2]) || (ld[1] && gnt_r[2]);
    sel[0]  = gnt_l[0] ? head[1] : (gnt_l[1] ? head[2] : head[3]);
    sel[1]  = gnt_r[0] ? head[0] : (gnt_r[1] ? head[2] : head[3]);
    sel[2]  = head[0];
    sel[3]  = head[1];
  end

  // ---- stage p0: input FIFOs ----
  // FIFO storage holds data only; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_flit[i];
    end
  end

  // FIFO pointers wrap naturally at DEPTH; reset empties every FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // ---- stage p1: output registers ----
  // Output registers hold while stalled and reload back-to-back when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= '0;
      for (int o = 0; o < 4; o++) flit_p1[o] <= '0;
    end else begin
      for (int o = 0; o < 4; o++) begin
        if (out_rdy[o]) begin
          vld_p1[o] <= ld[o];
          if (ld[o]) flit_p1[o] <= sel[o];
        end
      end
    end
  end

  // Round-robin pointers advance only on an actual load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_l <= 2'd0;
      ptr_r <= 2'd0;
    end else begin
      if (ld[0]) ptr_l <= next_ptr(gnt_l, ptr_l);
      if (ld[1]) ptr_r <= next_ptr(gnt_r, ptr_r);
    end
  end

  // Idle flag reflects the previous cycle: no buffered flit, no output, no input.
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= (nonempty == '0) && (vld_p1 == '0) && (in_vld == '0);
  end

endmodule

// File: tb/tb_pi_switch_fifo.sv
// Bench for pi_switch_fifo: two instances (round-robin and fixed priority) at
// N=8, posl=0, posx=2 share the same stimulus. Each output has its own
// expected-flit queue, filled when stimulus is driven and drained by the monitor.
module tb_pi_switch_fifo;

  localparam int A_W = 4;
  localparam int D_W = 32;
  localparam int FW  = A_W + D_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [FW-1:0] i_flit [4];
  logic [3:0]    i_v;
  logic [3:0]    bp_rr;
  logic [3:0]    bp_fp;
  logic [FW-1:0] o_flit [8];
  logic [7:0]    o_v;
  logic [7:0]    o_bp;
  logic          done_rr;
  logic          done_fp;
  logic [FW-1:0] exp_q [8][$];
  int            n_chk = 0;
  int            n_err = 0;

  pi_switch_fifo #(.N(8), .A_W(A_W), .D_W(D_W), .posl(0), .posx(2), .DEPTH(4), .RR(1)) dut_rr (
    .clk(clk), .rst(rst),
    .l_i(i_flit[0]),  .l_i_v(i_v[0]),  .l_i_bp(bp_rr[0]),
    .r_i(i_flit[1]),  .r_i_v(i_v[1]),  .r_i_bp(bp_rr[1]),
    .u0_i(i_flit[2]), .u0_i_v(i_v[2]), .u0_i_bp(bp_rr[2]),
    .u1_i(i_flit[3]), .u1_i_v(i_v[3]), .u1_i_bp(bp_rr[3]),
    .l_o(o_flit[0]),  .l_o_v(o_v[0]),  .l_o_bp(o_bp[0]),
    .r_o(o_flit[1]),  .r_o_v(o_v[1]),  .r_o_bp(o_bp[1]),
    .u0_o(o_flit[2]), .u0_o_v(o_v[2]), .u0_o_bp(o_bp[2]),
    .u1_o(o_flit[3]), .u1_o_v(o_v[3]), .u1_o_bp(o_bp[3]),
    .done(done_rr)
  );

  pi_switch_fifo #(.N(8), .A_W(A_W), .D_W(D_W), .posl(0), .posx(2), .DEPTH(4), .RR(0)) dut_fp (
    .clk(clk), .rst(rst),
    .l_i(i_flit[0]),  .l_i_v(i_v[0]),  .l_i_bp(bp_fp[0]),
    .r_i(i_flit[1]),  .r_i_v(i_v[1]),  .r_i_bp(bp_fp[1]),
    .u0_i(i_flit[2]), .u0_i_v(i_v[2]), .u0_i_bp(bp_fp[2]),
    .u1_i(i_flit[3]), .u1_i_v(i_v[3]), .u1_i_bp(bp_fp[3]),
    .l_o(o_flit[4]),  .l_o_v(o_v[4]),  .l_o_bp(o_bp[4]),
    .r_o(o_flit[5]),  .r_o_v(o_v[5]),  .r_o_bp(o_bp[5]),
    .u0_o(o_flit[6]), .u0_o_v(o_v[6]), .u0_o_bp(o_bp[6]),
    .u1_o(o_flit[7]), .u1_o_v(o_v[7]), .u1_o_bp(o_bp[7]),
    .done(done_fp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [FW-1:0] mkflit(input logic tag, input logic [A_W-1:0] addr,
                                           input logic [D_W-1:0] data);
    return {tag, addr, data};
  endfunction

  // Reference routing for posl=0, posx=2: addresses 2 and 3 belong below this switch.
  function automatic int route(input int src, input logic [A_W-1:0] addr);
    if (addr[A_W-1:1] == 3'd1 || src >= 2) return addr[0] ? 1 : 0;
    else                                   return (src == 0) ? 2 : 3;
  endfunction

  function automatic logic [FW-1:0] cflit(input int p, input int s);
    return mkflit(s[0], 4'd2, 32'hD000_0000 + 32'(p * 16 + s));
  endfunction

  task automatic wait_drain(input string tag);
    int tot;
    for (int c = 0; c < 60; c++) begin
      tot = 0;
      for (int k = 0; k < 8; k++) tot += exp_q[k].size();
      if (tot == 0) break;
      @(posedge clk); #1;
    end
    tot = 0;
    for (int k = 0; k < 8; k++) tot += exp_q[k].size();
    check(tag, tot, 0);
  endtask

  // Every transfer (valid and not stalled) must match the head of its expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        if (o_v[k] && !o_bp[k]) begin
          check($sformatf("exp_avail_o%0d", k), exp_q[k].size() != 0, 1);
          if (exp_q[k].size() != 0)
            check($sformatf("out_o%0d", k), o_flit[k], exp_q[k].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int            t_src  [7] = '{2, 2, 0, 1, 3, 1, 0};
    logic [3:0]    t_addr [7] = '{4'd2, 4'd3, 4'd5, 4'd2, 4'd3, 4'd6, 4'd3};
    logic          t_tag  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [FW-1:0] f;
    int            d;
    int            n;
    bit            stop;
    logic          any_v;

    i_v  = '0;
    o_bp = '0;
    for (int p = 0; p < 4; p++) i_flit[p] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_v", o_v, 0);
    check("rst_bp", {bp_rr, bp_fp}, 0);
    check("rst_done", {done_rr, done_fp}, 0);
    check("rst_l_o", o_flit[0], 0);
    check("rst_u1_o_fp", o_flit[7], 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_done", {done_rr, done_fp}, 2'b11);

    // Single flits: routing, tag pass-through, two-cycle latency.
    for (int t = 0; t < 7; t++) begin
      f = mkflit(t_tag[t], t_addr[t], 32'hA000_0000 + 32'(t));
      d = route(t_src[t], t_addr[t]);
      exp_q[d].push_back(f);
      exp_q[4 + d].push_back(f);
      i_flit[t_src[t]] = f;
      i_v[t_src[t]]    = 1'b1;
      @(posedge clk); #1;
      i_v = '0;
      check($sformatf("lat_t1_rr_%0d", t), o_v[d], 0);
      check($sformatf("lat_t1_fp_%0d", t), o_v[4 + d], 0);
      @(posedge clk); #1;
      check($sformatf("lat_t2_rr_%0d", t), o_v[d], 1);
      check($sformatf("lat_t2_fp_%0d", t), o_v[4 + d], 1);
      repeat (2) @(posedge clk);
      #1;
    end
    wait_drain("single_drain");

    // Stall l_o and stream u0 -> l until the FIFO fills.
    o_bp[0] = 1'b1;
    o_bp[4] = 1'b1;
    n    = 0;
    stop = 1'b0;
    for (int c = 0; c < 20 && !stop; c++) begin
      i_flit[2] = mkflit(1'b0, 4'd2, 32'hB000_0000 + 32'(n));
      i_v[2]    = 1'b1;
      @(negedge clk);
      if (bp_rr[2]) stop = 1'b1;
      else begin
        exp_q[0].push_back(i_flit[2]);
        exp_q[4].push_back(i_flit[2]);
        n++;
      end
      @(posedge clk); #1;
    end
    i_v = '0;
    check("bp_accepted", n, 5);
    check("bp_full_rr", bp_rr[2], 1);
    check("bp_full_fp", bp_fp[2], 1);
    for (int c = 0; c < 4; c++) begin
      check("hold_v_rr", o_v[0], 1);
      check("hold_flit_rr", o_flit[0], mkflit(1'b0, 4'd2, 32'hB000_0000));
      check("hold_flit_fp", o_flit[4], mkflit(1'b0, 4'd2, 32'hB000_0000));
      @(posedge clk); #1;
    end
    check("busy_done", {done_rr, done_fp}, 0);
    o_bp = '0;
    wait_drain("bp_drain");

    // Reset while flits are buffered behind a stalled output.
    o_bp[0] = 1'b1;
    o_bp[4] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_flit[2] = mkflit(1'b1, 4'd2, 32'hC000_0000 + 32'(c));
      i_v[2]    = 1'b1;
      @(posedge clk); #1;
    end
    i_v = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_o_v", o_v, 0);
    check("mid_rst_l_o", o_flit[0], 0);
    check("mid_rst_l_o_fp", o_flit[4], 0);
    check("mid_rst_bp", {bp_rr, bp_fp}, 0);
    check("mid_rst_done", {done_rr, done_fp}, 0);
    rst  = 1'b0;
    o_bp = '0;
    @(posedge clk); #1;
    check("post_rst_done", {done_rr, done_fp}, 2'b11);
    any_v = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      any_v |= |o_v;
    end
    check("no_stale", any_v, 0);

    // Three sources contend for l_o, three flits each, all launched together.
    for (int p = 1; p < 4; p++)
      for (int s = 0; s < 3; s++) exp_q[4].push_back(cflit(p, s));
    for (int s = 0; s < 3; s++) begin
      for (int p = 1; p < 4; p++) begin
        i_flit[p] = cflit(p, s);
        exp_q[0].push_back(cflit(p, s));
      end
      i_v = 4'b1110;
      @(posedge clk); #1;
    end
    i_v = '0;
    wait_drain("arb_drain");
    repeat (2) @(posedge clk);
    #1;
    check("final_done", {done_rr, done_fp}, 2'b11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
